// File: rtl/vend_pkg.sv
// Shared encodings for the vending controller: FSM states, coin codes and the coin unit.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    localparam int COIN_UNIT    = 5;
    localparam int NUM_PRODUCTS = 4;

    // Rupee value of a coin code; none and invalid both count as zero.
    function automatic logic [4:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  coin_value = 5'd5;
            COIN_10: coin_value = 5'd10;
            default: coin_value = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-product stock counters with bulk reload, single-product decrement and sold-out flags.
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       dec,
    input  logic [1:0] idx,
    output logic [3:0] sold_out
);

    localparam logic [STOCK_W-1:0] INIT_VAL = STOCK_W'(STOCK_INIT);

    logic [STOCK_W-1:0] stock [NUM_PRODUCTS];

    // NOTE: this array is a handful of counters, not a RAM, so every entry is reset.
    always_ff @(posedge clk) begin
        if (!reset || load) begin
            for (int i = 0; i < NUM_PRODUCTS; i++) stock[i] <= INIT_VAL;
        end else if (dec && stock[idx] != '0) begin
            stock[idx] <= stock[idx] - 1'b1;
        end
    end

    always_comb begin
        sold_out = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) sold_out[i] = (stock[i] == '0);
    end

endmodule

// File: rtl/vend_controller.sv
// Vending controller: coin credit, product selection, dispense handshake and change payout.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE0     = 15,
    parameter int PRICE1     = 20,
    parameter int PRICE2     = 25,
    parameter int PRICE3     = 30,
    parameter int MAX_CREDIT = 50,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8,
    localparam int CW        = $clog2(MAX_CREDIT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    in,
    input  logic [1:0]    sel,
    input  logic          sel_valid,
    input  logic          cancel,
    input  logic          refill,
    input  logic          vend_ack,
    input  logic          chg_ack,
    output logic [CW-1:0] credit,
    output logic          coin_reject,
    output logic          sel_err,
    output logic          vend_req,
    output logic [1:0]    vend_id,
    output logic          chg_req,
    output logic [3:0]    sold_out,
    output logic          busy
);

    localparam logic [CW:0]   MAX_C = (CW + 1)'(MAX_CREDIT);
    localparam logic [CW-1:0] UNIT  = CW'(COIN_UNIT);

    state_t        state;
    logic [CW-1:0] price;
    logic [CW:0]   credit_sum;
    logic          open_state;
    logic          cancel_ok;
    logic          sel_ok;
    logic          coin_ok;

    always_comb begin
        case (sel)
            2'd0:    price = CW'(PRICE0);
            2'd1:    price = CW'(PRICE1);
            2'd2:    price = CW'(PRICE2);
            default: price = CW'(PRICE3);
        endcase
    end

    // One extra bit so the ceiling check cannot be fooled by a wrapped sum.
    assign credit_sum = {1'b0, credit} + (CW + 1)'(coin_value(in));
    assign open_state = (state == ST_IDLE) || (state == ST_CREDIT);
    assign cancel_ok  = (state == ST_CREDIT) && cancel;
    assign sel_ok     = (state == ST_CREDIT) && sel_valid && !cancel &&
                        !sold_out[sel] && (credit >= price);
    assign coin_ok    = open_state && (in != COIN_NONE) && (in != COIN_BAD) &&
                        !cancel_ok && !sel_ok && (credit_sum <= MAX_C);

    vend_stock_bank #(
        .STOCK_W   (STOCK_W),
        .STOCK_INIT(STOCK_INIT)
    ) u_stock (
        .clk     (clk),
        .reset   (reset),
        .load    (refill && open_state),
        .dec     (sel_ok),
        .idx     (sel),
        .sold_out(sold_out)
    );

    // NOTE: pulses default low with non-blocking writes; a later write in the same block wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            credit      <= '0;
            coin_reject <= 1'b0;
            sel_err     <= 1'b0;
            vend_req    <= 1'b0;
            vend_id     <= 2'd0;
            chg_req     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            coin_reject <= (in != COIN_NONE) && !coin_ok;
            sel_err     <= sel_valid && !sel_ok && !cancel_ok;

            case (state)
                ST_IDLE, ST_CREDIT: begin
                    if (cancel_ok) begin
                        state   <= ST_CHANGE;
                        chg_req <= 1'b1;
                        busy    <= 1'b1;
                    end else if (sel_ok) begin
                        credit   <= credit - price;
                        state    <= ST_VEND;
                        vend_req <= 1'b1;
                        vend_id  <= sel;
                        busy     <= 1'b1;
                    end else if (coin_ok) begin
                        credit <= credit_sum[CW-1:0];
                        state  <= ST_CREDIT;
                    end
                end

                ST_VEND: begin
                    if (vend_ack) begin
                        vend_req <= 1'b0;
                        if (credit != '0) begin
                            state   <= ST_CHANGE;
                            chg_req <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    // Last coin out (or nothing left) returns straight to IDLE.
                    if (credit == '0) begin
                        chg_req <= 1'b0;
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (chg_req && chg_ack) begin
                        if (credit <= UNIT) begin
                            credit  <= '0;
                            chg_req <= 1'b0;
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            credit <= credit - UNIT;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: each step queues its expected outputs, then compares them after the edge.
module tb_vend_controller;

    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    in = 2'b00;
    logic [1:0]    sel = 2'd0;
    logic          sel_valid = 1'b0;
    logic          cancel = 1'b0;
    logic          refill = 1'b0;
    logic          vend_ack = 1'b0;
    logic          chg_ack = 1'b0;
    logic [CW-1:0] credit;
    logic          coin_reject;
    logic          sel_err;
    logic          vend_req;
    logic [1:0]    vend_id;
    logic          chg_req;
    logic [3:0]    sold_out;
    logic          busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        int         credit;
        logic       coin_reject;
        logic       sel_err;
        logic       vend_req;
        logic [1:0] vend_id;
        logic       chg_req;
        logic       busy;
        logic [3:0] sold_out;
    } exp_t;

    exp_t sb[$];

    vend_controller dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .cancel     (cancel),
        .refill     (refill),
        .vend_ack   (vend_ack),
        .chg_ack    (chg_ack),
        .credit     (credit),
        .coin_reject(coin_reject),
        .sel_err    (sel_err),
        .vend_req   (vend_req),
        .vend_id    (vend_id),
        .chg_req    (chg_req),
        .sold_out   (sold_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input string tag, input int cr, input logic rej, input logic se,
                                input logic vr, input int vid, input logic chg, input logic bsy,
                                input int so);
        exp_t e;
        e.tag         = tag;
        e.credit      = cr;
        e.coin_reject = rej;
        e.sel_err     = se;
        e.vend_req    = vr;
        e.vend_id     = 2'(vid);
        e.chg_req     = chg;
        e.busy        = bsy;
        e.sold_out    = 4'(so);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".credit"},      32'(credit),      32'(e.credit));
        check({e.tag, ".coin_reject"}, 32'(coin_reject), 32'(e.coin_reject));
        check({e.tag, ".sel_err"},     32'(sel_err),     32'(e.sel_err));
        check({e.tag, ".vend_req"},    32'(vend_req),    32'(e.vend_req));
        if (e.vend_req) check({e.tag, ".vend_id"}, 32'(vend_id), 32'(e.vend_id));
        check({e.tag, ".chg_req"},     32'(chg_req),     32'(e.chg_req));
        check({e.tag, ".busy"},        32'(busy),        32'(e.busy));
        check({e.tag, ".sold_out"},    32'(sold_out),    32'(e.sold_out));
    endtask

    // Inputs change 1 ns after a rising edge, hold for one cycle, outputs are checked 1 ns after the next edge.
    task automatic step(input logic [1:0] c, input logic sv, input logic [1:0] s, input logic cn,
                        input logic rf, input logic va, input logic ca, input exp_t e);
        in        = c;
        sel_valid = sv;
        sel       = s;
        cancel    = cn;
        refill    = rf;
        vend_ack  = va;
        chg_ack   = ca;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in        = 2'b00;
        sel_valid = 1'b0;
        cancel    = 1'b0;
        refill    = 1'b0;
        vend_ack  = 1'b0;
        chg_ack   = 1'b0;
        compare_out();
    endtask

    initial begin
        // 1: one reset cycle, then idle outputs
        sb.push_back(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        compare_out();

        // 2: exact payment for product 1, no change
        step(2'b10, 0, 0, 0, 0, 0, 0, mk("t2_c10a", 10, 0, 0, 0, 0, 0, 0, 0));
        step(2'b10, 0, 0, 0, 0, 0, 0, mk("t2_c10b", 20, 0, 0, 0, 0, 0, 0, 0));
        step(2'b00, 1, 1, 0, 0, 0, 0, mk("t2_sel1", 0, 0, 0, 1, 1, 0, 1, 0));
        step(2'b00, 0, 0, 0, 0, 0, 0, mk("t2_hold", 0, 0, 0, 1, 1, 0, 1, 0));
        step(2'b00, 0, 0, 0, 0, 1, 0, mk("t2_ack", 0, 0, 0, 0, 0, 0, 0, 0));

        // 3: overpay for product 0, three change coins
        step(2'b10, 0, 0, 0, 0, 0, 0, mk("t3_c1", 10, 0, 0, 0, 0, 0, 0, 0));
        step(2'b10, 0, 0, 0, 0, 0, 0, mk("t3_c2", 20, 0, 0, 0, 0, 0, 0, 0));
        step(2'b10, 0, 0, 0, 0, 0, 0, mk("t3_c3", 30, 0, 0, 0, 0, 0, 0, 0));
        step(2'b00, 1, 0, 0, 0, 0, 0, mk("t3_sel0", 15, 0, 0, 1, 0, 0, 1, 0));
        step(2'b00, 0, 0, 0, 0, 1, 0, mk("t3_ack", 15, 0, 0, 0, 0, 1, 1, 0));
        step(2'b00, 0, 0, 0, 0, 0, 0, mk("t3_wait", 15, 0, 0, 0, 0, 1, 1, 0));
        step(2'b00, 0, 0, 0, 0, 0, 1, mk("t3_chg1", 10, 0, 0, 0, 0, 1, 1, 0));
        step(2'b00, 0, 0, 0, 0, 0, 1, mk("t3_chg2", 5, 0, 0, 0, 0, 1, 1, 0));
        step(2'b00, 0, 0, 0, 0, 0, 1, mk("t3_chg3", 0, 0, 0, 0, 0, 0, 0, 0));

        // 4: credit ceiling, invalid coin, cancel with nine change coins
        for (int k = 1; k <= 4; k++)
            step(2'b10, 0, 0, 0, 0, 0, 0, mk("t4_fill", 10 * k, 0, 0, 0, 0, 0, 0, 0));
        step(2'b01, 0, 0, 0, 0, 0, 0, mk("t4_c5", 45, 0, 0, 0, 0, 0, 0, 0));
        step(2'b10, 0, 0, 0, 0, 0, 0, mk("t4_over", 45, 1, 0, 0, 0, 0, 0, 0));
        step(2'b11, 0, 0, 0, 0, 0, 0, mk("t4_bad", 45, 1, 0, 0, 0, 0, 0, 0));
        step(2'b00, 0, 0, 1, 0, 0, 0, mk("t4_cancel", 45, 0, 0, 0, 0, 1, 1, 0));
        step(2'b01, 0, 0, 0, 0, 0, 0, mk("t4_coin_chg", 45, 1, 0, 0, 0, 1, 1, 0));
        for (int k = 1; k <= 9; k++)
            step(2'b00, 0, 0, 0, 0, 0, 1,
                 mk("t4_refund", 45 - 5 * k, 0, 0, 0, 0, k < 9, k < 9, 0));

        // 5: low credit, drain product 2, sold-out refusal, refill
        step(2'b10, 0, 0, 0, 0, 0, 0, mk("t5_c10", 10, 0, 0, 0, 0, 0, 0, 0));
        step(2'b00, 1, 3, 0, 0, 0, 0, mk("t5_low", 10, 0, 1, 0, 0, 0, 0, 0));
        step(2'b00, 0, 0, 1, 0, 0, 0, mk("t5_cancel", 10, 0, 0, 0, 0, 1, 1, 0));
        step(2'b00, 0, 0, 0, 0, 0, 1, mk("t5_chg1", 5, 0, 0, 0, 0, 1, 1, 0));
        step(2'b00, 0, 0, 0, 0, 0, 1, mk("t5_chg2", 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            step(2'b10, 0, 0, 0, 0, 0, 0, mk("t5_d10a", 10, 0, 0, 0, 0, 0, 0, 0));
            step(2'b10, 0, 0, 0, 0, 0, 0, mk("t5_d10b", 20, 0, 0, 0, 0, 0, 0, 0));
            step(2'b01, 0, 0, 0, 0, 0, 0, mk("t5_d5", 25, 0, 0, 0, 0, 0, 0, 0));
            step(2'b00, 1, 2, 0, 0, 0, 0,
                 mk("t5_dsel", 0, 0, 0, 1, 2, 0, 1, (i == 7) ? 4 : 0));
            step(2'b00, 0, 0, 0, 0, 1, 0,
                 mk("t5_dack", 0, 0, 0, 0, 0, 0, 0, (i == 7) ? 4 : 0));
        end
        step(2'b10, 0, 0, 0, 0, 0, 0, mk("t5_r10a", 10, 0, 0, 0, 0, 0, 0, 4));
        step(2'b10, 0, 0, 0, 0, 0, 0, mk("t5_r10b", 20, 0, 0, 0, 0, 0, 0, 4));
        step(2'b10, 0, 0, 0, 0, 0, 0, mk("t5_r10c", 30, 0, 0, 0, 0, 0, 0, 4));
        step(2'b00, 1, 2, 0, 0, 0, 0, mk("t5_empty", 30, 0, 1, 0, 0, 0, 0, 4));
        step(2'b00, 0, 0, 0, 1, 0, 0, mk("t5_refill", 30, 0, 0, 0, 0, 0, 0, 0));

        // 6: reset mid-vend with credit 15 left
        step(2'b00, 1, 0, 0, 0, 0, 0, mk("t6_sel0", 15, 0, 0, 1, 0, 0, 1, 0));
        reset = 1'b0;
        step(2'b10, 0, 0, 0, 0, 1, 1, mk("t6_reset", 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        step(2'b00, 0, 0, 0, 0, 0, 0, mk("t6_idle", 0, 0, 0, 0, 0, 0, 0, 0));
        step(2'b01, 0, 0, 0, 0, 0, 0, mk("t6_coin", 5, 0, 0, 0, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
